lane_merge_mux: RTL

//  Parametrised N-to-1 lane merger with valid/ready handshake on every lane and on the output.

---
 rtl/lane_merge_pkg.sv | 17 +
 rtl/lane_merge_mux_if.sv | 37 +++
 rtl/lane_merge_mux_rr_arbiter.sv | 38 +++
 rtl/lane_merge_mux.sv | 90 +++++++++
 4 files changed

// File: rtl/lane_merge_pkg.sv
// Shared constants, types and helpers for the lane merge mux.
// Optional lane tagging is controlled by LANE_MERGE_TAG_EN.
package lane_merge_pkg;

  localparam int ARB_RR     = 0;
  localparam int ARB_FIXED  = 1;
  localparam int DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] lane_word_t;

  // Index width for n lanes; never narrower than one bit.
  function automatic int lane_idx_w(input int n);
    if ($clog2(n) < 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lane_merge_mux_if.sv
// Handshake bundle for the lane merge mux; lane_id only exists with LANE_MERGE_TAG_EN.
// valid/ready: a word moves on a lane when valid and ready are both high at a rising clk edge.
interface lane_merge_mux_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 4
);
  import lane_merge_pkg::*;

  localparam int IDX_W = lane_idx_w(NUM_LANES);

  logic [NUM_LANES*DATA_W-1:0] data_in;
  logic [NUM_LANES-1:0]        valid_in;
  logic [NUM_LANES-1:0]        ready_out;
  logic [DATA_W-1:0]           data_out;
  logic                        valid_out;
  logic                        ready_in;
`ifdef LANE_MERGE_TAG_EN
  logic [IDX_W-1:0]            lane_id;
`endif

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
`ifdef LANE_MERGE_TAG_EN
    , output lane_id
`endif
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
`ifdef LANE_MERGE_TAG_EN
    , input lane_id
`endif
  );

endinterface

// File: rtl/lane_merge_mux_rr_arbiter.sv
// Combinational lane arbiter: round-robin from ptr_i, or fixed lowest-index priority.
module rr_arbiter
  import lane_merge_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ARB_MODE  = ARB_RR,
  parameter int IDX_W     = lane_idx_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 en_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  int   start;
  int   k;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = 0;
    start     = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr_i);
    for (int i = 0; i < NUM_LANES; i++) begin
      k = start + i;
      if (k >= NUM_LANES) k = k - NUM_LANES;
      if (!found && req_i[k]) begin
        found     = 1'b1;
        gnt_idx_o = IDX_W'(k);
      end
    end
    // gnt_idx_o stays informative when disabled; only the one-hot is gated.
    if (found && en_i) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/lane_merge_mux.sv
// N-to-1 lane merger with a registered output stage and per-lane valid/ready.
// Define LANE_MERGE_TAG_EN to add the registered lane_id source tag.
module lane_merge_mux
  import lane_merge_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 4,
  parameter int ARB_MODE  = ARB_RR
) (
  input  logic             clk,
  input  logic             reset,
  lane_merge_mux_if.slave  bus
);

  localparam int IDX_W = lane_idx_w(NUM_LANES);

  logic                 load;
  logic                 take;
  logic [NUM_LANES-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
`ifdef LANE_MERGE_TAG_EN
  logic [IDX_W-1:0]     lane_q, lane_d;
`endif

  // The register can accept a word when empty or being drained this cycle.
  assign load = !valid_q | bus.ready_in;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .ARB_MODE  (ARB_MODE),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req_i     (bus.valid_in),
    .ptr_i     (rr_ptr_q),
    .en_i      (load & !reset),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign bus.ready_out = gnt;
  assign take          = |gnt;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
`ifdef LANE_MERGE_TAG_EN
    lane_d   = lane_q;
`endif
    if (take) begin
      data_d  = bus.data_in[int'(gnt_idx)*DATA_W +: DATA_W];
      valid_d = 1'b1;
`ifdef LANE_MERGE_TAG_EN
      lane_d  = gnt_idx;
`endif
      if (ARB_MODE == ARB_RR)
        rr_ptr_d = (gnt_idx == IDX_W'(NUM_LANES-1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
`ifdef LANE_MERGE_TAG_EN
      lane_q   <= '0;
`endif
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef LANE_MERGE_TAG_EN
      lane_q   <= lane_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
`ifdef LANE_MERGE_TAG_EN
  assign bus.lane_id   = lane_q;
`endif

endmodule
